// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: one req/gnt + rvalid bus read per IF PC, holding IF via o_stall.
// Define IMEM_ERR_EN to add bus-error handling (i_rerr input, o_fetch_err output).
module imem_fetch_ctrl #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      TIMEOUT_CYC = 255,
    parameter logic [WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_redirect,
    output logic [WIDTH-1:0] o_instr,
    output logic             o_stall,
    output logic             o_req,
    output logic [WIDTH-1:0] o_addr,
    input  logic             i_gnt,
    input  logic             i_rvalid,
    input  logic [WIDTH-1:0] i_rdata,
`ifdef IMEM_ERR_EN
    input  logic             i_rerr,
    output logic             o_fetch_err,
`endif
    output logic             o_timeout
);

    localparam int unsigned   CW         = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e           state_d, state_q;
    logic [WIDTH-1:0] instr_d, instr_q;
    logic             stall_d, stall_q;
    logic             req_d, req_q;
    logic [WIDTH-1:0] addr_d, addr_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             discard_d, discard_q;
    logic             timeout_d, timeout_q;
`ifdef IMEM_ERR_EN
    logic             fetch_err_d, fetch_err_q;
`endif

    // Next-state and next-output decode for the fetch sequence.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        timeout_d = timeout_q;
`ifdef IMEM_ERR_EN
        fetch_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i_redirect) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (i_gnt) begin
                    state_d = ST_WAIT;
                    cnt_d   = {CW{1'b0}};
                    addr_d  = i_pc;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_redirect) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                // A response in the timeout cycle still delivers real data.
                if (i_rvalid) begin
                    state_d = ST_RESP;
                    if (discard_q || i_redirect) begin
                        instr_d = NOP_INSTR;
                    end
`ifdef IMEM_ERR_EN
                    else if (i_rerr) begin
                        instr_d     = NOP_INSTR;
                        fetch_err_d = 1'b1;
                    end
`endif
                    else begin
                        instr_d = i_rdata;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_RESP;
                    instr_d   = NOP_INSTR;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d   = ST_REQ;
                discard_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d   = (state_d == ST_REQ);
        stall_d = (state_d != ST_RESP);
    end

    // State and output registers; reset abandons any in-flight read.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            instr_q     <= NOP_INSTR;
            stall_q     <= 1'b1;
            req_q       <= 1'b0;
            addr_q      <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            discard_q   <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef IMEM_ERR_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            stall_q     <= stall_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            timeout_q   <= timeout_d;
`ifdef IMEM_ERR_EN
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    // IF's PC only settles to the next fetch address at the RESP edge, so the
    // bus address follows i_pc live while requesting and holds the granted one after.
    assign o_addr    = req_q ? i_pc : addr_q;
    assign o_instr   = instr_q;
    assign o_stall   = stall_q;
    assign o_req     = req_q;
    assign o_timeout = timeout_q;
`ifdef IMEM_ERR_EN
    assign o_fetch_err = fetch_err_q;
`endif

endmodule
